// File: rtl/ext_pkg.sv
// Shared definitions for immediate extension: mode encoding and its width.
package ext_pkg;

    localparam int EXT_MODE_W = 2;

    typedef logic [EXT_MODE_W-1:0] ext_mode_t;

    localparam ext_mode_t EXT_ZERO   = 2'b00;
    localparam ext_mode_t EXT_SIGN   = 2'b01;
    localparam ext_mode_t EXT_UPPER  = 2'b10;
    localparam ext_mode_t EXT_BRANCH = 2'b11;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: widens valin to size_out bits
// in zero, sign, upper-load or branch-offset form.
module imm_ext_core
    import ext_pkg::*;
#(
    parameter int size_in  = 16,
    parameter int size_out = 32,
    parameter int br_shift = 2
) (
    input  logic [size_in-1:0]  valin,
    input  ext_mode_t           mode,
    output logic [size_out-1:0] extended
);

    localparam int EXT_W = size_out - size_in;

    // Upper and branch forms must fit without losing any significant bits.
    if ((size_out < size_in + br_shift) || (size_out < 2 * size_in)) begin : g_param_check
        $error("imm_ext_core: size_out too small for size_in/br_shift");
    end

    logic [size_out-1:0] zeroExt;
    logic [size_out-1:0] signExt;

    assign zeroExt = {{EXT_W{1'b0}}, valin};
    assign signExt = {{EXT_W{valin[size_in-1]}}, valin};

    always_comb begin
        extended = zeroExt;
        case (mode)
            EXT_ZERO:   extended = zeroExt;
            EXT_SIGN:   extended = signExt;
            EXT_UPPER:  extended = zeroExt << size_in;
            EXT_BRANCH: extended = signExt << br_shift;
            default:    extended = zeroExt;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage elastic immediate extender between decode and the ALU operand mux.
// S1 holds the raw immediate, S2 holds the extended result; both advance with valid/ready.
module imm_extend_pipe
    import ext_pkg::*;
#(
    parameter int size_in  = 16,
    parameter int size_out = 32,
    parameter int br_shift = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [size_in-1:0]  valin,
    input  ext_mode_t           mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [size_out-1:0] extended,
    output ext_mode_t           out_mode
);

    logic                s1Valid_q, s1Valid_d;
    logic [size_in-1:0]  s1Val_q,   s1Val_d;
    ext_mode_t           s1Mode_q,  s1Mode_d;
    logic                outValid_q, outValid_d;
    logic [size_out-1:0] ext_q,     ext_d;
    ext_mode_t           outMode_q, outMode_d;
    logic                s2Load;
    logic [size_out-1:0] coreExt;

    imm_ext_core #(
        .size_in  (size_in),
        .size_out (size_out),
        .br_shift (br_shift)
    ) u_core (
        .valin    (s1Val_q),
        .mode     (s1Mode_q),
        .extended (coreExt)
    );

    // A stage loads when it is empty or its current contents leave this cycle.
    always_comb begin
        s2Load     = s1Valid_q && (!outValid_q || out_ready);
        in_ready   = !s1Valid_q || s2Load;
        s1Valid_d  = s1Valid_q;
        s1Val_d    = s1Val_q;
        s1Mode_d   = s1Mode_q;
        outValid_d = outValid_q;
        ext_d      = ext_q;
        outMode_d  = outMode_q;
        if (in_ready) begin
            s1Valid_d = in_valid;
            if (in_valid) begin
                s1Val_d  = valin;
                s1Mode_d = mode;
            end
        end
        if (s2Load) begin
            outValid_d = 1'b1;
            ext_d      = coreExt;
            outMode_d  = s1Mode_q;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q  <= 1'b0;
            s1Val_q    <= '0;
            s1Mode_q   <= EXT_ZERO;
            outValid_q <= 1'b0;
            ext_q      <= '0;
            outMode_q  <= EXT_ZERO;
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1Val_q    <= s1Val_d;
            s1Mode_q   <= s1Mode_d;
            outValid_q <= outValid_d;
            ext_q      <= ext_d;
            outMode_q  <= outMode_d;
        end
    end

    assign out_valid = outValid_q;
    assign extended  = ext_q;
    assign out_mode  = outMode_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: default instance plus a size_in=12/br_shift=1 instance.
module tb_imm_extend_pipe;
    import ext_pkg::*;

    logic        clk = 1'b0;
    logic        rst;

    logic        aInValid, aInReady, aOutValid, aOutReady;
    logic [15:0] aValin;
    ext_mode_t   aMode, aOutMode;
    logic [31:0] aExt;

    logic        bInValid, bInReady, bOutValid, bOutReady;
    logic [11:0] bValin;
    ext_mode_t   bMode, bOutMode;
    logic [31:0] bExt;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    imm_extend_pipe dutA (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (aInValid),
        .in_ready  (aInReady),
        .valin     (aValin),
        .mode      (aMode),
        .out_valid (aOutValid),
        .out_ready (aOutReady),
        .extended  (aExt),
        .out_mode  (aOutMode)
    );

    imm_extend_pipe #(.size_in(12), .size_out(32), .br_shift(1)) dutB (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bInValid),
        .in_ready  (bInReady),
        .valin     (bValin),
        .mode      (bMode),
        .out_valid (bOutValid),
        .out_ready (bOutReady),
        .extended  (bExt),
        .out_mode  (bOutMode)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        else
            passCount++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one immediate through an otherwise idle pipe and checks 2-cycle latency and drain.
    task automatic applyStimulus(input bit useB, input logic [15:0] v, input ext_mode_t m,
                                 input logic [31:0] exp, input string tag);
        if (useB) begin
            bInValid = 1'b1; bValin = v[11:0]; bMode = m; bOutReady = 1'b1;
        end else begin
            aInValid = 1'b1; aValin = v; aMode = m; aOutReady = 1'b1;
        end
        #1;
        checkOutput({tag, "_inrdy"}, 32'(useB ? bInReady : aInReady), 32'd1);
        step();
        aInValid = 1'b0; bInValid = 1'b0;
        #1;
        checkOutput({tag, "_lat1"}, 32'(useB ? bOutValid : aOutValid), 32'd0);
        step();
        checkOutput({tag, "_valid"}, 32'(useB ? bOutValid : aOutValid), 32'd1);
        checkOutput({tag, "_data"}, useB ? bExt : aExt, exp);
        checkOutput({tag, "_mode"}, 32'(useB ? bOutMode : aOutMode), 32'(m));
        step();
        checkOutput({tag, "_drain"}, 32'(useB ? bOutValid : aOutValid), 32'd0);
    endtask

    initial begin
        int expIdx, sendIdx, nOut, firstCyc, lastCyc;
        bit stallSeen, prevValid, prevXfer, acceptNow;
        logic [31:0] prevExt;

        rst = 1'b1;
        aInValid = 1'b0; aValin = '0; aMode = EXT_ZERO; aOutReady = 1'b1;
        bInValid = 1'b0; bValin = '0; bMode = EXT_ZERO; bOutReady = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(aOutValid), 32'd0);
        checkOutput("rst_ext",   aExt, 32'd0);
        checkOutput("rst_mode",  32'(aOutMode), 32'd0);
        checkOutput("rst_inrdy", 32'(aInReady), 32'd1);

        // Every mode with the default parameters, then boundary immediates.
        applyStimulus(1'b0, 16'h8001, EXT_ZERO,   32'h00008001, "zero");
        applyStimulus(1'b0, 16'h8001, EXT_SIGN,   32'hFFFF8001, "sign");
        applyStimulus(1'b0, 16'h8001, EXT_UPPER,  32'h80010000, "upper");
        applyStimulus(1'b0, 16'h8001, EXT_BRANCH, 32'hFFFE0004, "branch");
        applyStimulus(1'b0, 16'h7FFF, EXT_SIGN,   32'h00007FFF, "sign_max");
        applyStimulus(1'b0, 16'hFFFF, EXT_BRANCH, 32'hFFFFFFFC, "br_neg1");
        applyStimulus(1'b0, 16'h0000, EXT_UPPER,  32'h00000000, "upper_zero");

        // Backpressure: four SIGN items, consumer stalled in cycles 3..6.
        expIdx = 0; sendIdx = 0; stallSeen = 0; prevValid = 0; prevXfer = 0; prevExt = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            aOutReady = !(cyc >= 3 && cyc <= 6);
            aInValid  = (sendIdx < 4);
            aValin    = 16'(sendIdx + 1);
            aMode     = EXT_SIGN;
            #1;
            if (prevValid && !prevXfer) begin
                checkOutput("bp_hold_valid", 32'(aOutValid), 32'd1);
                checkOutput("bp_hold_data", aExt, prevExt);
            end
            if (aOutValid && aOutReady) begin
                checkOutput("bp_order", aExt, 32'(expIdx + 1));
                expIdx++;
            end
            if (aInValid && !aInReady) stallSeen = 1'b1;
            acceptNow = aInValid && aInReady;
            prevValid = aOutValid;
            prevXfer  = aOutValid && aOutReady;
            prevExt   = aExt;
            step();
            if (acceptNow) sendIdx++;
        end
        aInValid = 1'b0; aOutReady = 1'b1;
        checkOutput("bp_count", 32'(expIdx), 32'd4);
        checkOutput("bp_stalled", 32'(stallSeen), 32'd1);

        // Full throughput: eight back-to-back items.
        nOut = 0; firstCyc = -1; lastCyc = -1;
        for (int c = 0; c < 14; c++) begin
            aInValid = (c < 8);
            aValin   = 16'h8000 | 16'(c);
            aMode    = EXT_SIGN;
            #1;
            if (c < 8) checkOutput("tp_inrdy", 32'(aInReady), 32'd1);
            if (aOutValid) begin
                if (firstCyc < 0) firstCyc = c;
                lastCyc = c;
                checkOutput("tp_data", aExt, {16'hFFFF, 16'h8000 | 16'(nOut)});
                nOut++;
            end
            step();
        end
        aInValid = 1'b0;
        checkOutput("tp_count", 32'(nOut), 32'd8);
        checkOutput("tp_first", 32'(firstCyc), 32'd2);
        checkOutput("tp_last",  32'(lastCyc), 32'd9);

        // Reset with both stages full and a simultaneous handshake offered.
        aOutReady = 1'b0;
        aInValid = 1'b1; aValin = 16'h0055; aMode = EXT_SIGN;
        step();
        aValin = 16'h0066;
        step();
        aInValid = 1'b0;
        #1;
        checkOutput("full_inrdy", 32'(aInReady), 32'd0);
        checkOutput("full_data", aExt, 32'h00000055);
        rst = 1'b1; aInValid = 1'b1; aValin = 16'h1234; aOutReady = 1'b1;
        step();
        rst = 1'b0; aInValid = 1'b0;
        #1;
        checkOutput("mrst_valid", 32'(aOutValid), 32'd0);
        checkOutput("mrst_ext",   aExt, 32'd0);
        checkOutput("mrst_inrdy", 32'(aInReady), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput("mrst_quiet", 32'(aOutValid), 32'd0);
        end

        // Alternate parameters: size_in=12, br_shift=1.
        applyStimulus(1'b1, 16'h0800, EXT_BRANCH, 32'hFFFFF000, "b_branch");
        applyStimulus(1'b1, 16'h0800, EXT_SIGN,   32'hFFFFF800, "b_sign");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
